pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Central stall/flush scheduler for the 5-stage MIPS pipeline. It combines four hazard sources into one prioritised set of pipeline-register write enables and flushes:
- load-use data hazard
- taken branch resolved in ID
- multi-cycle mult/div occupying EX
- data-memory wait
It owns a small FSM and latency counter for the mult/div unit, plus a saturating stall-cycle performance counter.

Parameters:
MD_LAT, 32, total stall cycles per mult/div op including the issue cycle; legal range 2..255.
CNT_W, 16, width of stall performance counter.

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
IDEX_memRead  input  1  instruction in EX is a load
IFID_regRs  input  5  rs of instruction in ID
IFID_regRt  input  5  rt of instruction in ID
IDEX_regRt  input  5  destination rt of load in EX
branch_taken  input  1  branch/jump in ID resolved taken
md_start  input  1  mult/div issuing in EX this cycle
dmem_req  input  1  MEM stage accessing data memory
dmem_ready  input  1  data memory completes this cycle
perf_clr  input  1  synchronous clear of stall_cnt
PCWrite  output  1  PC update enable
IFID_write  output  1  IF/ID register enable
IDEX_write  output  1  ID/EX register enable
EXMEM_write  output  1  EX/MEM register enable
IF_flush  output  1  zero IF/ID contents (bubble into ID)
ID_flush  output  1  zero control into ID/EX (bubble into EX)
EX_flush  output  1  zero control into EX/MEM (bubble into MEM)
MEMWB_flush  output  1  zero control into MEM/WB (bubble into WB)
md_busy  output  1  FSM in MD_BUSY
md_done  output  1  one-cycle pulse, last mult/div stall cycle
stall_cnt  output  CNT_W  saturating count of cycles with PCWrite=0

Behaviour:
- State: FSM {RUN, MD_BUSY}; 8-bit down-counter md_cnt; stall_cnt.
- Outputs are combinational from state and current inputs, so stalls take effect in the same cycle.
- Async reset (rst_n=0):
  - state=RUN, md_cnt=0, stall_cnt=0.
  - While rst_n=0, outputs are forced: all *_write=1, all flushes=0, md_busy=0, md_done=0.
- Derived conditions:
  - mem_wait = dmem_req & ~dmem_ready.
  - load_use = IDEX_memRead & (IDEX_regRt != 0) & (IFID_regRs==IDEX_regRt | IFID_regRt==IDEX_regRt).
- Default (RUN, no condition): all *_write=1, all flushes=0.
- Priority is highest first; exactly one action applies per cycle.
  1. mem_wait, any state:
     - PCWrite = IFID_write = IDEX_write = EXMEM_write = 0.
     - MEMWB_flush=1; all other flushes 0.
     - md_start ignored (the EX instruction is frozen and re-presents it).
     - md_cnt still decrements in MD_BUSY, and FSM transitions still occur.
  2. MD_BUSY, or RUN with md_start:
     - PCWrite = IFID_write = IDEX_write = 0.
     - EXMEM_write=1, EX_flush=1.
  3. load_use in RUN:
     - PCWrite = IFID_write = 0, ID_flush=1, for exactly one cycle.
     - No state change. A concurrent branch_taken is dropped; the branch re-asserts once the stall clears.
  4. branch_taken in RUN: IF_flush=1 for one cycle, PCWrite=1.
- FSM:
  - RUN -> MD_BUSY on md_start & ~mem_wait; md_cnt <= MD_LAT-2.
  - MD_BUSY with md_cnt != 0: md_cnt decrements.
  - MD_BUSY with md_cnt == 0: md_done=1 that cycle, next state RUN.
  - Total stalled cycles per op = MD_LAT (issue cycle + MD_LAT-1 MD_BUSY cycles).
  - md_start asserted while in MD_BUSY is ignored.
- stall_cnt:
  - Increments on each rising edge where PCWrite=0.
  - Saturates at all-ones.
  - perf_clr has priority over increment (count <= 0).
- Reset mid-operation: an MD_BUSY sequence is abandoned immediately; md_done is not pulsed.

Test Plan:
1. Load-use: IDEX_memRead=1, IDEX_regRt=5, IFID_regRs=5 for 1 cycle -> PCWrite=0, IFID_write=0, ID_flush=1 that cycle only; stall_cnt=1. Repeat with IDEX_regRt=0 -> no stall.
2. Branch: branch_taken=1, no hazards -> IF_flush=1, PCWrite=1 for one cycle. Branch_taken plus load-use in the same cycle -> IF_flush=0, ID_flush=1.
3. Mult/div, MD_LAT=4: md_start pulse at cycle 0 -> PCWrite=0 for cycles 0-3; md_busy=1 for cycles 1-3; md_done=1 at cycle 3; EX_flush=1 for cycles 0-3; PCWrite=1 at cycle 4; stall_cnt=4.
4. Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles during MD_BUSY -> all writes 0, MEMWB_flush=1, md_cnt keeps counting; RUN is still reached MD_LAT cycles after issue.
5. Reset: drop rst_n at MD_BUSY cycle 2 -> outputs immediately at defaults, state RUN, stall_cnt=0; no md_done pulse after release.
6. Saturation: CNT_W=4, hold mem_wait 20 cycles -> stall_cnt stops at 15; perf_clr together with a stall in the same cycle -> stall_cnt=0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage MIPS pipeline: prioritises memory wait,
// mult/div occupancy, load-use and taken-branch hazards, and counts stall cycles.
module pipeline_stall_ctrl #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IDEX_memRead,
    input  logic [4:0]       IFID_regRs,
    input  logic [4:0]       IFID_regRt,
    input  logic [4:0]       IDEX_regRt,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             perf_clr,
    output logic             PCWrite,
    output logic             IFID_write,
    output logic             IDEX_write,
    output logic             EXMEM_write,
    output logic             IF_flush,
    output logic             ID_flush,
    output logic             EX_flush,
    output logic             MEMWB_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {RUN, MD_BUSY} state_t;

    // The issue cycle is spent in RUN, so MD_BUSY covers the remaining MD_LAT-1 cycles.
    localparam logic [7:0] MD_INIT = 8'(MD_LAT - 2);

    state_t     state;
    logic [7:0] md_cnt;
    logic       mem_wait;
    logic       load_use;
    logic       md_active;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == {CNT_W{1'b1}})
            return val;
        return val + 1'b1;
    endfunction

    assign mem_wait  = dmem_req & ~dmem_ready;
    assign load_use  = IDEX_memRead & (IDEX_regRt != 5'd0) &
                       ((IFID_regRs == IDEX_regRt) | (IFID_regRt == IDEX_regRt));
    assign md_active = (state == MD_BUSY) | md_start;
    assign md_busy   = (state == MD_BUSY);
    assign md_done   = (state == MD_BUSY) && (md_cnt == 8'd0);

    always_comb begin
        PCWrite     = 1'b1;
        IFID_write  = 1'b1;
        IDEX_write  = 1'b1;
        EXMEM_write = 1'b1;
        IF_flush    = 1'b0;
        ID_flush    = 1'b0;
        EX_flush    = 1'b0;
        MEMWB_flush = 1'b0;
        if (!rst_n) begin
            PCWrite = 1'b1;
        end else if (mem_wait) begin
            PCWrite     = 1'b0;
            IFID_write  = 1'b0;
            IDEX_write  = 1'b0;
            EXMEM_write = 1'b0;
            MEMWB_flush = 1'b1;
        end else if (md_active) begin
            PCWrite    = 1'b0;
            IFID_write = 1'b0;
            IDEX_write = 1'b0;
            EX_flush   = 1'b1;
        end else if (load_use) begin
            // Any concurrent branch is dropped; ID re-resolves it after the bubble.
            PCWrite    = 1'b0;
            IFID_write = 1'b0;
            ID_flush   = 1'b1;
        end else if (branch_taken) begin
            IF_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= 8'd0;
        end else begin
            case (state)
                RUN: begin
                    if (md_start && !mem_wait) begin
                        state  <= MD_BUSY;
                        md_cnt <= MD_INIT;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt == 8'd0)
                        state <= RUN;
                    else
                        md_cnt <= md_cnt - 8'd1;
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (perf_clr)
            stall_cnt <= '0;
        else if (!PCWrite)
            stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (MD_LAT=4, CNT_W=4).
module tb_pipeline_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       IDEX_memRead;
    logic [4:0] IFID_regRs, IFID_regRt, IDEX_regRt;
    logic       branch_taken, md_start, dmem_req, dmem_ready, perf_clr;
    logic       PCWrite, IFID_write, IDEX_write, EXMEM_write;
    logic       IF_flush, ID_flush, EX_flush, MEMWB_flush, md_busy, md_done;
    logic [3:0] stall_cnt;
    logic [9:0] ctl;

    int n_vec = 0;
    int n_miscmp = 0;

    // {PCWrite,IFID_write,IDEX_write,EXMEM_write, IF_flush,ID_flush,EX_flush,MEMWB_flush, md_busy,md_done}
    localparam logic [9:0] C_DEF   = 10'b1111_0000_00;
    localparam logic [9:0] C_LU    = 10'b0011_0100_00;
    localparam logic [9:0] C_BR    = 10'b1111_1000_00;
    localparam logic [9:0] C_ISSUE = 10'b0001_0010_00;
    localparam logic [9:0] C_BUSY  = 10'b0001_0010_10;
    localparam logic [9:0] C_LAST  = 10'b0001_0010_11;
    localparam logic [9:0] C_MW    = 10'b0000_0001_00;
    localparam logic [9:0] C_MWB   = 10'b0000_0001_10;
    localparam logic [9:0] C_MWL   = 10'b0000_0001_11;

    pipeline_stall_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .IDEX_memRead(IDEX_memRead), .IFID_regRs(IFID_regRs), .IFID_regRt(IFID_regRt),
        .IDEX_regRt(IDEX_regRt), .branch_taken(branch_taken), .md_start(md_start),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
        .PCWrite(PCWrite), .IFID_write(IFID_write), .IDEX_write(IDEX_write),
        .EXMEM_write(EXMEM_write), .IF_flush(IF_flush), .ID_flush(ID_flush),
        .EX_flush(EX_flush), .MEMWB_flush(MEMWB_flush), .md_busy(md_busy),
        .md_done(md_done), .stall_cnt(stall_cnt)
    );

    assign ctl = {PCWrite, IFID_write, IDEX_write, EXMEM_write,
                  IF_flush, ID_flush, EX_flush, MEMWB_flush, md_busy, md_done};

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        IDEX_memRead = 1'b0; IFID_regRs = 5'd0; IFID_regRt = 5'd0; IDEX_regRt = 5'd0;
        branch_taken = 1'b0; md_start = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
        perf_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ldrt);
        IDEX_memRead = 1'b1; IFID_regRs = rs; IFID_regRt = rt; IDEX_regRt = ldrt;
    endtask

    task automatic clear_cnt();
        idle(); perf_clr = 1'b1; tick(); perf_clr = 1'b0;
    endtask

    initial begin
        // Reset: hazards present but outputs forced to defaults
        idle();
        rst_n = 1'b0;
        set_lu(5'd5, 5'd0, 5'd5);
        md_start = 1'b1;
        #3;
        check_val("rst_ctl", 32'(ctl), 32'(C_DEF));
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_cnt", 32'(stall_cnt), 32'd0);
        check_val("rst_busy", 32'(md_busy), 32'd0);
        idle();
        rst_n = 1'b1;
        #2;
        check_val("idle_ctl", 32'(ctl), 32'(C_DEF));
        tick();

        // Load-use via rs, then via rt, then register 0 never stalls
        set_lu(5'd5, 5'd0, 5'd5);
        #2 check_val("lu_rs_ctl", 32'(ctl), 32'(C_LU));
        tick(); idle();
        #2 check_val("lu_after_ctl", 32'(ctl), 32'(C_DEF));
        check_val("lu_cnt", 32'(stall_cnt), 32'd1);
        set_lu(5'd3, 5'd7, 5'd7);
        #2 check_val("lu_rt_ctl", 32'(ctl), 32'(C_LU));
        tick();
        set_lu(5'd0, 5'd0, 5'd0);
        #2 check_val("lu_r0_ctl", 32'(ctl), 32'(C_DEF));
        tick(); idle();
        check_val("lu_r0_cnt", 32'(stall_cnt), 32'd2);

        // Branch alone, then branch with load-use
        branch_taken = 1'b1;
        #2 check_val("br_ctl", 32'(ctl), 32'(C_BR));
        tick();
        set_lu(5'd9, 5'd0, 5'd9);
        #2 check_val("br_lu_ctl", 32'(ctl), 32'(C_LU));
        tick(); idle();
        #2 check_val("br_done_ctl", 32'(ctl), 32'(C_DEF));
        check_val("br_cnt", 32'(stall_cnt), 32'd3);

        // Mult/div: 4 stalled cycles, md_start during busy ignored
        clear_cnt();
        check_val("clr_cnt", 32'(stall_cnt), 32'd0);
        md_start = 1'b1;
        #2 check_val("md_c0", 32'(ctl), 32'(C_ISSUE));
        tick(); md_start = 1'b0;
        #2 check_val("md_c1", 32'(ctl), 32'(C_BUSY));
        tick(); md_start = 1'b1;
        #2 check_val("md_c2", 32'(ctl), 32'(C_BUSY));
        tick(); md_start = 1'b0;
        #2 check_val("md_c3", 32'(ctl), 32'(C_LAST));
        tick();
        #2 check_val("md_c4", 32'(ctl), 32'(C_DEF));
        check_val("md_cnt", 32'(stall_cnt), 32'd4);

        // md_start under memory wait in RUN does not issue
        clear_cnt();
        md_start = 1'b1; dmem_req = 1'b1;
        #2 check_val("mw_start_ctl", 32'(ctl), 32'(C_MW));
        tick(); idle();
        #2 check_val("mw_start_nobusy", 32'(ctl), 32'(C_DEF));

        // Memory wait during MD_BUSY: counter keeps running
        clear_cnt();
        md_start = 1'b1;
        #2 check_val("mwb_c0", 32'(ctl), 32'(C_ISSUE));
        tick(); md_start = 1'b0; dmem_req = 1'b1;
        #2 check_val("mwb_c1", 32'(ctl), 32'(C_MWB));
        tick();
        #2 check_val("mwb_c2", 32'(ctl), 32'(C_MWB));
        tick();
        #2 check_val("mwb_c3", 32'(ctl), 32'(C_MWL));
        tick(); idle();
        #2 check_val("mwb_c4", 32'(ctl), 32'(C_DEF));
        check_val("mwb_cnt", 32'(stall_cnt), 32'd4);

        // Reset in the middle of MD_BUSY
        md_start = 1'b1;
        tick(); md_start = 1'b0;
        tick();
        #2 check_val("rmid_c2", 32'(ctl), 32'(C_BUSY));
        rst_n = 1'b0;
        #1 check_val("rmid_ctl", 32'(ctl), 32'(C_DEF));
        check_val("rmid_cnt", 32'(stall_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2 check_val($sformatf("rmid_post%0d", i), 32'(ctl), 32'(C_DEF));
            tick();
        end

        // Saturation at 15, then perf_clr beats a concurrent stall
        clear_cnt();
        dmem_req = 1'b1;
        repeat (20) tick();
        check_val("sat_cnt", 32'(stall_cnt), 32'd15);
        perf_clr = 1'b1;
        tick();
        check_val("clr_stall_cnt", 32'(stall_cnt), 32'd0);
        perf_clr = 1'b0;
        tick();
        check_val("post_clr_cnt", 32'(stall_cnt), 32'd1);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
